player_motion_ctrl: RTL and testbench
=====================================

Name: player_motion_ctrl

Overview:
- Parametrised successor to the single-jump player controller: tick-based jump/gravity physics, cliff fall-through, landing cooldown, an N-frame run animation and a packed sprite descriptor.
- Sits between the keyboard/button front end and the sprite renderer.
- Consumes the terrain `on_ground` flag and the global `game_over` flag.

Parameters:
- GROUND_Y, 400, ground surface y; reset y.
- MIN_Y, 32, ceiling clamp.
- FLOOR_Y, 480, screen bottom; reaching it means fell.
- X_START, 80, fixed player x.
- TICK_CYCLES, 100000, clocks per physics tick (>=2).
- JUMP_V0, 8, initial upward speed in px/tick (1..127).
- GRAVITY, 1, px/tick added to velocity per tick.
- MAX_FALL_V, 8, downward velocity cap.
- COOLDOWN_TICKS, 4, ticks after landing before a new jump is accepted.
- NUM_FRAMES, 5, run-animation frames (1..8).
- FRAME_TICKS, 10, physics ticks per animation frame.
- EDGE_HIST, 8, idle-history length for jump qualification.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- jump  in  1  raw jump request (button OR space key)
- game_over  in  1  freeze all motion and animation
- on_ground  in  1  terrain solid under player x
- pos_x  out  10  player x
- pos_y  out  10  player y (top-left)
- vel  out  8  signed velocity, negative = up
- state  out  2  0 GROUNDED, 1 AIRBORNE, 2 FELL
- fell  out  1  sticky; player dropped to FLOOR_Y
- sprite_desc  out  32  {5'b10000, 1'b0, pos_x, pos_y, row[2:0], col[2:0]}

Behaviour:
- Clock is clk; reset is synchronous, active-high.
- Reset values: pos_x=X_START, pos_y=GROUND_Y, vel=0, state=GROUNDED, fell=0, frame=0, cooldown=0, tick counter=0, jump history=0.
- Tick: counter runs 0..TICK_CYCLES-1 and pulses `tick` on the terminal count. The counter keeps running during game_over, but ticks are ignored while game_over=1.
- Jump qualification:
  - History shifts in `jump` every cycle.
  - `jreq` = jump & (history == 0), i.e. jump was low for the previous EDGE_HIST cycles.
  - A held key never re-triggers.
- Jump accept: jreq & !game_over & state==GROUNDED & cooldown==0. On the next clock: vel=-JUMP_V0, state=AIRBORNE.
  - The first y change occurs on the next tick.
  - A jreq not accepted is dropped, not queued.
- Per tick in AIRBORNE, evaluated in this order with 11-bit signed arithmetic:
  - ny = y + vel.
  - If ny < MIN_Y: y=MIN_Y, vel=0.
  - Else if vel>=0 and on_ground and y<=GROUND_Y and ny>=GROUND_Y: y=GROUND_Y, vel=0, state=GROUNDED, cooldown=COOLDOWN_TICKS.
  - Else if ny>=FLOOR_Y: y=FLOOR_Y, vel=0, state=FELL, fell=1.
  - Else: y=ny, then vel=min(vel+GRAVITY, MAX_FALL_V).
- GROUNDED:
  - If on_ground=0 on a tick (walked onto a cliff): state=AIRBORNE, vel=0; falling starts on the following tick.
  - cooldown decrements by 1 per tick down to 0.
- Simultaneous accept and on_ground=0 in the same cycle: the jump wins.
- FELL is terminal until reset. fell stays high; jumps are ignored.
- Animation:
  - frame advances every FRAME_TICKS ticks, only while GROUNDED and !game_over.
  - Wraps NUM_FRAMES-1 → 0.
  - Frame phase and frame value are held (not cleared) while airborne.
- Sprite row/col, in priority order:
  - game_over → 0/0.
  - FELL → 2/0.
  - AIRBORNE, vel<0 → 1/0.
  - AIRBORNE, vel>=0 → 1/1.
  - Else 0/frame.
- sprite_desc is combinational from registered state (0-cycle latency from registers).
- game_over: all registers hold except the tick counter and jump history. Deasserting resumes mid-jump exactly where it stopped.
- Reset mid-jump: restores all reset values on the next edge.

Optional Feature:
- Macro DOUBLE_JUMP_EN.
- When defined:
  - One extra jump is allowed while AIRBORNE, on an accepted jreq.
  - The extra jump sets vel=-JUMP_V0 on the next clock.
  - A double-jump-used flag is set by the air jump and cleared on landing or reset.
  - Sprite row/col = 1/2 while rising after an air jump.
- When undefined: jreq in AIRBORNE is ignored; behaviour is exactly as above.

Test Plan:
- Bench parameters for all scenarios: TICK_CYCLES=4, JUMP_V0=8, GRAVITY=1, MAX_FALL_V=8, COOLDOWN_TICKS=4, on_ground=1 unless stated.
- Jump from rest: pos_y goes 392, 385, ..., 364 over ticks 1–8, is 364 at tick 9, then 365 ... 400 at tick 17; state returns to GROUNDED, vel=0.
- Held jump: jump held high for 200 cycles → exactly one jump. Re-press inside the 4-tick cooldown → ignored. Re-press after cooldown → accepted.
- Cliff: on_ground=0 while GROUNDED → AIRBORNE. y descends 400, 401, 403, 406, ... until 480, then state=FELL and fell=1. Further jump presses have no effect.
- Ceiling: MIN_Y=380, jump → y clamps at 380 with vel=0, then falls back and lands at 400.
- Freeze: game_over asserted at y=370 for 50 cycles → pos_y, vel and frame are unchanged and row/col=0/0. Deassert → trajectory continues from 370.
- Animation and double jump: NUM_FRAMES=5, FRAME_TICKS=2, grounded → col cycles 0..4..0 every 8 clocks. With DOUBLE_JUMP_EN, a second press at tick 5 → vel=-8 again; a third press → ignored.

Source files
------------

// File: rtl/player_motion_ctrl.sv
// Tick-based player motion controller: jump/gravity physics, cliff fall, landing cooldown,
// run animation and packed sprite descriptor. Optional air jump with `define DOUBLE_JUMP_EN.
module player_motion_ctrl #(
    parameter int GROUND_Y       = 400,
    parameter int MIN_Y          = 32,
    parameter int FLOOR_Y        = 480,
    parameter int X_START        = 80,
    parameter int TICK_CYCLES    = 100000,
    parameter int JUMP_V0        = 8,
    parameter int GRAVITY        = 1,
    parameter int MAX_FALL_V     = 8,
    parameter int COOLDOWN_TICKS = 4,
    parameter int NUM_FRAMES     = 5,
    parameter int FRAME_TICKS    = 10,
    parameter int EDGE_HIST      = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        jump,
    input  logic        game_over,
    input  logic        on_ground,
    output logic [9:0]  pos_x,
    output logic [9:0]  pos_y,
    output logic [7:0]  vel,
    output logic [1:0]  state,
    output logic        fell,
    output logic [31:0] sprite_desc
);

    localparam int TW  = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam int PW  = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;
    localparam int CDW = (COOLDOWN_TICKS > 0) ? $clog2(COOLDOWN_TICKS + 1) : 1;

    localparam logic signed [10:0] GROUND_Y_S = 11'(GROUND_Y);
    localparam logic signed [10:0] MIN_Y_S    = 11'(MIN_Y);
    localparam logic signed [10:0] FLOOR_Y_S  = 11'(FLOOR_Y);
    localparam logic signed [7:0]  JUMP_VEL   = 8'(-JUMP_V0);
    localparam logic signed [8:0]  GRAV_S     = 9'(GRAVITY);
    localparam logic signed [8:0]  MAXV_S     = 9'(MAX_FALL_V);

    typedef enum logic [1:0] {
        ST_GROUNDED = 2'd0,
        ST_AIRBORNE = 2'd1,
        ST_FELL     = 2'd2
    } state_t;

    logic [TW-1:0]        r_tick_cnt;
    logic [EDGE_HIST-1:0] r_hist;
    logic [9:0]           r_y;
    logic signed [7:0]    r_vel;
    state_t               r_state;
    logic                 r_fell;
    logic [2:0]           r_frame;
    logic [PW-1:0]        r_phase;
    logic [CDW-1:0]       r_cooldown;

    logic                 w_tick;
    logic                 w_run;
    logic                 w_jreq;
    logic                 w_ground_accept;
    logic                 w_air_accept;
    logic                 w_dj_used;
    logic signed [10:0]   w_y_s;
    logic signed [10:0]   w_vel_s;
    logic signed [10:0]   w_ny;
    logic                 w_hit_ceil;
    logic                 w_land;
    logic                 w_hit_floor;
    logic [2:0]           w_row;
    logic [2:0]           w_col;

    // Gravity step with downward speed cap.
    function automatic logic signed [7:0] sat_fall(input logic signed [7:0] v);
        logic signed [8:0] s;
        s = {v[7], v} + GRAV_S;
        return (s > MAXV_S) ? MAXV_S[7:0] : s[7:0];
    endfunction

    assign w_tick          = (r_tick_cnt == TW'(TICK_CYCLES - 1));
    assign w_run           = w_tick & ~game_over;
    assign w_jreq          = jump & (r_hist == '0);
    assign w_ground_accept = w_jreq & ~game_over & (r_state == ST_GROUNDED) & (r_cooldown == '0);

    assign w_y_s   = {1'b0, r_y};
    assign w_vel_s = {{3{r_vel[7]}}, r_vel};
    assign w_ny    = w_y_s + w_vel_s;

    assign w_hit_ceil  = (w_ny < MIN_Y_S);
    assign w_land      = ~w_hit_ceil & ~r_vel[7] & on_ground &
                         (w_y_s <= GROUND_Y_S) & (w_ny >= GROUND_Y_S);
    assign w_hit_floor = ~w_hit_ceil & ~w_land & (w_ny >= FLOOR_Y_S);

`ifdef DOUBLE_JUMP_EN
    logic r_dj_used;

    assign w_air_accept = w_jreq & ~game_over & (r_state == ST_AIRBORNE) & ~r_dj_used;
    assign w_dj_used    = r_dj_used;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_dj_used <= 1'b0;
        end else if (w_air_accept) begin
            r_dj_used <= 1'b1;
        end else if (w_run && r_state == ST_AIRBORNE && w_land) begin
            r_dj_used <= 1'b0;
        end
    end
`else
    assign w_air_accept = 1'b0;
    assign w_dj_used    = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_tick_cnt <= '0;
            r_hist     <= '0;
            r_y        <= 10'(GROUND_Y);
            r_vel      <= '0;
            r_state    <= ST_GROUNDED;
            r_fell     <= 1'b0;
            r_frame    <= '0;
            r_phase    <= '0;
            r_cooldown <= '0;
        end else begin
            r_hist     <= (r_hist << 1) | EDGE_HIST'(jump);
            r_tick_cnt <= w_tick ? '0 : r_tick_cnt + 1'b1;

            // Run animation only advances on the ground; phase is kept across jumps.
            if (w_run && r_state == ST_GROUNDED) begin
                if (r_phase == PW'(FRAME_TICKS - 1)) begin
                    r_phase <= '0;
                    r_frame <= (r_frame == 3'(NUM_FRAMES - 1)) ? 3'd0 : r_frame + 3'd1;
                end else begin
                    r_phase <= r_phase + 1'b1;
                end
            end

            if (!game_over) begin
                case (r_state)
                    ST_GROUNDED: begin
                        if (w_ground_accept) begin
                            r_vel   <= JUMP_VEL;
                            r_state <= ST_AIRBORNE;
                        end else if (w_tick) begin
                            if (!on_ground) begin
                                r_vel   <= '0;
                                r_state <= ST_AIRBORNE;
                            end
                            if (r_cooldown != '0) begin
                                r_cooldown <= r_cooldown - 1'b1;
                            end
                        end
                    end
                    ST_AIRBORNE: begin
                        if (w_air_accept) begin
                            r_vel <= JUMP_VEL;
                        end else if (w_tick) begin
                            if (w_hit_ceil) begin
                                r_y   <= 10'(MIN_Y);
                                r_vel <= '0;
                            end else if (w_land) begin
                                r_y        <= 10'(GROUND_Y);
                                r_vel      <= '0;
                                r_state    <= ST_GROUNDED;
                                r_cooldown <= CDW'(COOLDOWN_TICKS);
                            end else if (w_hit_floor) begin
                                r_y     <= 10'(FLOOR_Y);
                                r_vel   <= '0;
                                r_state <= ST_FELL;
                                r_fell  <= 1'b1;
                            end else begin
                                r_y   <= w_ny[9:0];
                                r_vel <= sat_fall(r_vel);
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        w_row = 3'd0;
        w_col = 3'd0;
        if (game_over) begin
            w_row = 3'd0;
            w_col = 3'd0;
        end else if (r_state == ST_FELL) begin
            w_row = 3'd2;
        end else if (r_state == ST_AIRBORNE) begin
            w_row = 3'd1;
            if (r_vel[7]) begin
                w_col = w_dj_used ? 3'd2 : 3'd0;
            end else begin
                w_col = 3'd1;
            end
        end else begin
            w_col = r_frame;
        end
    end

    assign pos_x       = 10'(X_START);
    assign pos_y       = r_y;
    assign vel         = r_vel;
    assign state       = r_state;
    assign fell        = r_fell;
    assign sprite_desc = {5'b10000, 1'b0, pos_x, pos_y, w_row, w_col};

endmodule

// File: tb/tb_player_motion_ctrl.sv
// Scoreboard bench for player_motion_ctrl: expected {y, vel, state, fell} records are queued by
// the stimulus and popped by a monitor whenever the DUT's motion outputs change.
module tb_player_motion_ctrl;

    typedef struct packed {
        logic [9:0] y;
        logic [7:0] v;
        logic [1:0] st;
        logic       f;
    } obs_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        game_over = 1'b0;
    logic        jump_a = 1'b0, on_ground_a = 1'b1;
    logic        jump_b = 1'b0, on_ground_b = 1'b1;
    logic [9:0]  pos_x_a, pos_y_a, pos_x_b, pos_y_b;
    logic [7:0]  vel_a, vel_b;
    logic [1:0]  state_a, state_b;
    logic        fell_a, fell_b;
    logic [31:0] sprite_a, sprite_b;

    int   nvec = 0;
    int   nbad = 0;
    logic mon_en = 1'b0;
    obs_t qa[$];
    obs_t qb[$];
    obs_t prev_a, prev_b, cur_a, cur_b, exp_a, exp_b;

    always #5 clk = ~clk;

    player_motion_ctrl #(.TICK_CYCLES(4), .FRAME_TICKS(2)) dut_a (
        .clk(clk), .reset(reset), .jump(jump_a), .game_over(game_over), .on_ground(on_ground_a),
        .pos_x(pos_x_a), .pos_y(pos_y_a), .vel(vel_a), .state(state_a), .fell(fell_a),
        .sprite_desc(sprite_a)
    );

    player_motion_ctrl #(.TICK_CYCLES(4), .MIN_Y(380)) dut_b (
        .clk(clk), .reset(reset), .jump(jump_b), .game_over(game_over), .on_ground(on_ground_b),
        .pos_x(pos_x_b), .pos_y(pos_y_b), .vel(vel_b), .state(state_b), .fell(fell_b),
        .sprite_desc(sprite_b)
    );

    always @(negedge clk) begin
        cur_a = {pos_y_a, vel_a, state_a, fell_a};
        if (mon_en && cur_a != prev_a) begin
            nvec++;
            if (qa.size() == 0) begin
                nbad++;
                $display("FAIL traj_a unexpected change: got y=%0d v=%0d st=%0d f=%0d, required no change",
                         cur_a.y, $signed(cur_a.v), cur_a.st, cur_a.f);
            end else begin
                exp_a = qa.pop_front();
                if (exp_a != cur_a) begin
                    nbad++;
                    $display("FAIL traj_a: got y=%0d v=%0d st=%0d f=%0d, required y=%0d v=%0d st=%0d f=%0d",
                             cur_a.y, $signed(cur_a.v), cur_a.st, cur_a.f,
                             exp_a.y, $signed(exp_a.v), exp_a.st, exp_a.f);
                end
            end
        end
        prev_a = cur_a;
    end

    always @(negedge clk) begin
        cur_b = {pos_y_b, vel_b, state_b, fell_b};
        if (mon_en && cur_b != prev_b) begin
            nvec++;
            if (qb.size() == 0) begin
                nbad++;
                $display("FAIL traj_b unexpected change: got y=%0d v=%0d st=%0d f=%0d, required no change",
                         cur_b.y, $signed(cur_b.v), cur_b.st, cur_b.f);
            end else begin
                exp_b = qb.pop_front();
                if (exp_b != cur_b) begin
                    nbad++;
                    $display("FAIL traj_b: got y=%0d v=%0d st=%0d f=%0d, required y=%0d v=%0d st=%0d f=%0d",
                             cur_b.y, $signed(cur_b.v), cur_b.st, cur_b.f,
                             exp_b.y, $signed(exp_b.v), exp_b.st, exp_b.f);
                end
            end
        end
        prev_b = cur_b;
    end

    function automatic obs_t mk(input int y, input int v, input int st, input int f);
        obs_t o;
        o.y  = 10'(y);
        o.v  = 8'(v);
        o.st = 2'(st);
        o.f  = 1'(f);
        return o;
    endfunction

    function automatic void pa(input int y, input int v, input int st = 1, input int f = 0);
        qa.push_back(mk(y, v, st, f));
    endfunction

    function automatic void pb(input int y, input int v, input int st = 1, input int f = 0);
        qb.push_back(mk(y, v, st, f));
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        nvec++;
        if (act !== req) begin
            nbad++;
            $display("FAIL %s: got %0h, required %0h", nm, act, req);
        end
    endtask

    task automatic pulse_a();
        jump_a = 1'b1;
        step(1);
        jump_a = 1'b0;
    endtask

    task automatic drain(input string nm, input int budget);
        int i;
        for (i = 0; i < budget && (qa.size() != 0 || qb.size() != 0); i++) step(1);
        nvec++;
        if (qa.size() != 0 || qb.size() != 0) begin
            nbad++;
            $display("FAIL %s timeout: got %0d/%0d records pending, required 0/0", nm, qa.size(), qb.size());
        end
    endtask

    task automatic wait_y_a(input string nm, input int y, input int budget);
        int i;
        for (i = 0; i < budget && pos_y_a != 10'(y); i++) step(1);
        chk(nm, {22'd0, pos_y_a}, 32'(y));
    endtask

    // Jump from rest, split at y=370 (tick 5) so freeze/air-press tests can resume from there.
    function automatic void push_rise_a();
        pa(400,-8); pa(392,-7); pa(385,-6); pa(379,-5); pa(374,-4); pa(370,-3);
    endfunction

    function automatic void push_rest_a();
        pa(367,-2); pa(365,-1); pa(364,0); pa(364,1); pa(365,2); pa(367,3);
        pa(370,4); pa(374,5); pa(379,6); pa(385,7); pa(392,8); pa(400,0,0);
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, required finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        mon_en = 1'b1;

        chk("reset_pos_x", {22'd0, pos_x_a}, 32'd80);
        chk("reset_pos_y", {22'd0, pos_y_a}, 32'd400);
        chk("reset_vel",   {24'd0, vel_a}, 32'd0);
        chk("reset_state", {30'd0, state_a}, 32'd0);
        chk("reset_fell",  {31'd0, fell_a}, 32'd0);
        chk("reset_sprite", sprite_a, {5'b10000, 1'b0, 10'd80, 10'd400, 3'd0, 3'd0});

        // Run animation: frame steps every 2 ticks = 8 clocks.
        step(7);  chk("anim_c7",  {26'd0, sprite_a[5:0]}, {26'd0, 3'd0, 3'd0});
        step(1);  chk("anim_c8",  {26'd0, sprite_a[5:0]}, {26'd0, 3'd0, 3'd1});
        step(8);  chk("anim_c16", {26'd0, sprite_a[5:0]}, {26'd0, 3'd0, 3'd2});
        step(16); chk("anim_c32", {26'd0, sprite_a[5:0]}, {26'd0, 3'd0, 3'd4});
        step(8);  chk("anim_c40", {26'd0, sprite_a[5:0]}, {26'd0, 3'd0, 3'd0});

        // Held jump: one full trajectory only.
        push_rise_a(); push_rest_a();
        jump_a = 1'b1;
        step(10);  chk("rise_sprite", {26'd0, sprite_a[5:0]}, {26'd0, 3'd1, 3'd0});
        step(40);  chk("fall_sprite", {26'd0, sprite_a[5:0]}, {26'd0, 3'd1, 3'd1});
        step(150);
        jump_a = 1'b0;
        drain("held_jump", 100);
        chk("held_state", {30'd0, state_a}, 32'd0);
        chk("held_vel",   {24'd0, vel_a}, 32'd0);

        // Cooldown: re-press 10 clocks after landing is dropped, later press accepted.
        step(10);
        push_rise_a(); push_rest_a();
        pulse_a();
        drain("jump2", 150);
        step(10);
        pulse_a();
        step(30);
        chk("cooldown_state", {30'd0, state_a}, 32'd0);
        push_rise_a(); push_rest_a();
        pulse_a();
        drain("jump3", 150);

        // Freeze mid-jump at y=370.
        step(20);
        push_rise_a();
        pulse_a();
        wait_y_a("freeze_reach", 370, 100);
        game_over = 1'b1;
        step(25);
        chk("freeze_y",      {22'd0, pos_y_a}, 32'd370);
        chk("freeze_vel",    {24'd0, vel_a}, 32'h0000_00FD);
        chk("freeze_sprite", {26'd0, sprite_a[5:0]}, 32'd0);
        step(25);
        chk("freeze_y2",     {22'd0, pos_y_a}, 32'd370);
        push_rest_a();
        game_over = 1'b0;
        drain("unfreeze", 150);

        // Presses while airborne.
        step(20);
        push_rise_a();
        pulse_a();
        wait_y_a("air_reach", 370, 100);
`ifdef DOUBLE_JUMP_EN
        pa(370,-8); pa(362,-7); pa(355,-6); pa(349,-5); pa(344,-4); pa(340,-3); pa(337,-2);
        pa(335,-1); pa(334,0); pa(334,1); pa(335,2); pa(337,3); pa(340,4); pa(344,5);
        pa(349,6); pa(355,7); pa(362,8); pa(370,8); pa(378,8); pa(386,8); pa(394,8); pa(400,0,0);
        pulse_a();
        step(5);
        chk("dj_sprite", {26'd0, sprite_a[5:0]}, {26'd0, 3'd1, 3'd2});
`else
        push_rest_a();
        pulse_a();
        step(5);
`endif
        step(10);
        pulse_a();
        drain("air_press", 250);

        // Cliff: fall through to the floor, then jumps are ignored.
        step(20);
        pa(400,0); pa(400,1); pa(401,2); pa(403,3); pa(406,4); pa(410,5); pa(415,6); pa(421,7);
        pa(428,8); pa(436,8); pa(444,8); pa(452,8); pa(460,8); pa(468,8); pa(476,8); pa(480,0,2,1);
        on_ground_a = 1'b0;
        drain("cliff", 200);
        chk("fell_flag",   {31'd0, fell_a}, 32'd1);
        chk("fell_state",  {30'd0, state_a}, 32'd2);
        chk("fell_sprite", {26'd0, sprite_a[5:0]}, {26'd0, 3'd2, 3'd0});
        step(10);
        pulse_a();
        step(20);
        chk("fell_hold_y",  {22'd0, pos_y_a}, 32'd480);
        chk("fell_hold_st", {30'd0, state_a}, 32'd2);

        // Reset out of FELL restores rest state.
        pa(400,0,0,0);
        on_ground_a = 1'b1;
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        drain("reset_fell", 5);
        chk("reset2_fell", {31'd0, fell_a}, 32'd0);

        // Ceiling clamp on the MIN_Y=380 instance.
        step(10);
        pb(400,-8); pb(392,-7); pb(385,-6); pb(380,0); pb(380,1); pb(381,2);
        pb(383,3); pb(386,4); pb(390,5); pb(395,6); pb(400,0,0);
        jump_b = 1'b1;
        step(1);
        jump_b = 1'b0;
        drain("ceiling", 150);
        chk("ceiling_state", {30'd0, state_b}, 32'd0);

        step(5);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end

endmodule
